// File: rtl/sram_store_writer.sv
// sram_store_writer: loads cfg_len stream beats into consecutive SRAM
// addresses starting at cfg_base, then pulses done for one cycle.
// Optional feature macro: STORE_LAST_CHK_EN (s_last consistency check
// driving the sticky err_last flag; when undefined err_last is tied low).
module sram_store_writer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic              err_last
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              accept;
    logic              last_beat;
    logic              start_take;

    assign accept     = s_valid & s_ready;
    assign last_beat  = (cnt_q == (len_q - LEN_W'(1)));
    assign start_take = (state == IDLE) && start;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        s_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = (cfg_len != '0) ? LOAD : DONE;
            end
            LOAD: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid && last_beat) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Transfer parameters, beat counter and registered SRAM write port
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
        end else begin
            if (start_take && (cfg_len != '0)) begin
                base_q <= cfg_base;
                len_q  <= cfg_len;
                cnt_q  <= '0;
            end
            sram_we <= accept;
            if (accept) begin
                sram_addr <= base_q + ADDR_W'(cnt_q);
                sram_din  <= s_data;
                cnt_q     <= cnt_q + LEN_W'(1);
            end
        end
    end

`ifdef STORE_LAST_CHK_EN
    // Sticky s_last mismatch flag; cleared by any start taken in IDLE
    always_ff @(posedge clk) begin
        if (reset)                              err_last <= 1'b0;
        else if (start_take)                    err_last <= 1'b0;
        else if (accept && (s_last != last_beat)) err_last <= 1'b1;
    end
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign err_last      = 1'b0;
`endif

endmodule
